data_memory_responder: RTL

//  Responder (memory side) of the data-memory twowire interface driven by the load/store MemoryUnit.

---
 rtl/data_memory_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// ----------------------------------------------------------------------------
// data_memory_responder
//
// Memory-side responder for the twowire data-memory interface used by the
// load/store MemoryUnit. One read or write is accepted at a time, held for
// LATENCY cycles and then acknowledged with a single-cycle o_req_ready pulse.
// Read data is presented on o_rdata in that same cycle. Writes commit at the
// end of the ready cycle. Used as the behavioural/FPGA data memory.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req_valid      request valid, held by the requester until ready
//   o_req_ready      registered one-cycle completion pulse
//   i_req_r0w1       0 = read, 1 = write
//   i_req_rwaddr     byte address (word index taken from bits [2 +: log2(DEPTH)])
//   i_req_wdata      write data
//   o_rdata          read data, valid with o_req_ready on reads, held otherwise
//   i_init_*         backdoor preload port, honoured only when idle and no request
//   o_rd_count       saturating count of completed reads
//   o_wr_count       saturating count of completed writes
//   o_protocol_err   sticky flag: valid dropped while a request was in flight
// ----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_ADDRESS        = 32,
    parameter int DEPTH             = 256,
    parameter int LATENCY           = 2,
    parameter int BW_CNT            = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_req_valid,
    output logic                                o_req_ready,
    input  logic                                i_req_r0w1,
    input  logic        [BW_ADDRESS-1:0]        i_req_rwaddr,
    input  logic signed [BW_PROCESSOR_DATA-1:0] i_req_wdata,
    output logic        [BW_PROCESSOR_DATA-1:0] o_rdata,
    input  logic                                i_init_we,
    input  logic        [$clog2(DEPTH)-1:0]     i_init_addr,
    input  logic        [BW_PROCESSOR_DATA-1:0] i_init_wdata,
    output logic        [BW_CNT-1:0]            o_rd_count,
    output logic        [BW_CNT-1:0]            o_wr_count,
    output logic                                o_protocol_err
);

    localparam int AW = $clog2(DEPTH);
    // Wide enough to hold LATENCY-1, never narrower than one bit.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                                state;
    logic        [CW-1:0]                  cnt;
    logic                                  cap_r0w1;
    logic        [AW-1:0]                  cap_idx;
    logic signed [BW_PROCESSOR_DATA-1:0]   cap_wdata;
    logic        [BW_PROCESSOR_DATA-1:0]   mem [DEPTH];

    logic [AW-1:0] req_idx;
    assign req_idx = i_req_rwaddr[2 +: AW];

    // Byte-offset and upper address bits are deliberately ignored, so
    // addresses alias onto the word array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_rwaddr[1:0], i_req_rwaddr[BW_ADDRESS-1:2+AW]};

    // Whole responder in one clocked process: the FSM, the captured request,
    // the storage array and every output are registers. Read data is fetched
    // on the transition into RESP so it lines up with the ready pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_r0w1       <= 1'b0;
            cap_idx        <= '0;
            cap_wdata      <= '0;
            o_req_ready    <= 1'b0;
            o_rdata        <= '0;
            o_rd_count     <= '0;
            o_wr_count     <= '0;
            o_protocol_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            o_req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        cap_r0w1  <= i_req_r0w1;
                        cap_idx   <= req_idx;
                        cap_wdata <= i_req_wdata;
                        cnt       <= CW'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            o_req_ready <= 1'b1;
                            if (!i_req_r0w1) begin
                                o_rdata <= mem[req_idx];
                            end
                        end else begin
                            state <= BUSY;
                        end
                    end else if (i_init_we) begin
                        mem[i_init_addr] <= i_init_wdata;
                    end
                end
                BUSY: begin
                    if (!i_req_valid) begin
                        o_protocol_err <= 1'b1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state       <= RESP;
                        o_req_ready <= 1'b1;
                        if (!cap_r0w1) begin
                            o_rdata <= mem[cap_idx];
                        end
                    end
                end
                RESP: begin
                    // Always return to IDLE so a valid still held high here is
                    // not mistaken for a fresh request in this cycle.
                    if (!i_req_valid) begin
                        o_protocol_err <= 1'b1;
                    end
                    if (cap_r0w1) begin
                        mem[cap_idx] <= cap_wdata;
                        if (o_wr_count != '1) begin
                            o_wr_count <= o_wr_count + 1'b1;
                        end
                    end else begin
                        if (o_rd_count != '1) begin
                            o_rd_count <= o_rd_count + 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
